// File: rtl/sifive_scope_tl_trace_capture.sv
// sifive_scope_tl_trace_capture
//   Snoops NUM_CH valid/ready channels of a TileLink bundle and records completed
//   handshake beats (payload, channel index, timestamp) into a circular trace
//   buffer. A beat on a trigger channel starts a post-trigger countdown, after
//   which the buffer freezes and is drained oldest-first over a valid/ready port.
//
// Ports
//   clock, reset       core clock, synchronous active-high reset
//   ch_valid/ch_ready  snooped handshake per channel (never driven here)
//   ch_payload         channel i payload at [i*PAYLOAD_W +: PAYLOAD_W]
//   ch_enable          per-channel capture enable
//   trig_mask          channels whose captured beat is the trigger
//   post_count         beats captured after the trigger (0..DEPTH)
//   arm                pulse: start a new capture (from IDLE or DONE)
//   rd_valid/rd_ready  readout handshake, active in DONE only
//   rd_data/rd_ch/rd_ts  oldest buffered entry (zero when rd_valid is low)
//   state              0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   drop_cnt           beats lost to same-cycle collisions, saturating at 255
module sifive_scope_tl_trace_capture #(
  parameter int NUM_CH    = 5,
  parameter int PAYLOAD_W = 64,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH-1:0]           ch_ready,
  input  logic [NUM_CH*PAYLOAD_W-1:0] ch_payload,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic [NUM_CH-1:0]           trig_mask,
  input  logic [CNT_W-1:0]            post_count,
  input  logic                        arm,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [PAYLOAD_W-1:0]        rd_data,
  output logic [CH_W-1:0]             rd_ch,
  output logic [TS_W-1:0]             rd_ts,
  output logic [1:0]                  state,
  output logic [7:0]                  drop_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_reg;
  logic [TS_W-1:0]  ts_reg;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, remaining_reg;
  logic [7:0]       drop_reg;

  logic [PAYLOAD_W-1:0] mem_payload [DEPTH];
  logic [CH_W-1:0]      mem_ch      [DEPTH];
  logic [TS_W-1:0]      mem_ts      [DEPTH];

  logic [PAYLOAD_W-1:0] payload_arr [NUM_CH];
  logic [NUM_CH-1:0]    fire;
  logic [NUM_CH-1:0]    fire_lowest;
  logic [CH_W-1:0]      sel_ch;
  logic [3:0]           fire_cnt;
  logic                 capturing;
  logic                 trig_hit;
  logic [8:0]           drop_sum;
  logic [7:0]           drop_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_payload
      assign payload_arr[gi] = ch_payload[gi*PAYLOAD_W +: PAYLOAD_W];
    end
  endgenerate

  assign fire        = ch_valid & ch_ready & ch_enable;
  // Isolate the lowest set bit: that channel wins the single write port.
  assign fire_lowest = fire & (~fire + NUM_CH'(1));
  assign trig_hit    = |(fire_lowest & trig_mask);
  assign capturing   = ((state_reg == ST_ARMED) || (state_reg == ST_POST)) && (|fire);

  always_comb begin
    sel_ch   = '0;
    fire_cnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fire[i]) sel_ch = CH_W'(i);
      fire_cnt = fire_cnt + 4'(fire[i]);
    end
  end

  // Only meaningful while capturing (fire_cnt >= 1); every beat past the first is lost.
  assign drop_sum  = {1'b0, drop_reg} + 9'(fire_cnt) - 9'd1;
  assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  // Buffer storage carries no reset; validity is tracked by count_reg.
  always_ff @(posedge clock) begin
    if (!reset && capturing) begin
      mem_payload[wr_ptr_reg] <= payload_arr[sel_ch];
      mem_ch[wr_ptr_reg]      <= sel_ch;
      mem_ts[wr_ptr_reg]      <= ts_reg;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ts_reg        <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      remaining_reg <= '0;
      drop_reg      <= '0;
    end else begin
      ts_reg <= ts_reg + TS_W'(1);
      case (state_reg)
        ST_IDLE: begin
          if (arm) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= '0;
            state_reg  <= ST_ARMED;
          end
        end
        ST_ARMED, ST_POST: begin
          if (capturing) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            // A full buffer drops its oldest entry to make room.
            if (count_reg == CNT_W'(DEPTH)) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            else                            count_reg  <= count_reg + CNT_W'(1);
            drop_reg <= drop_next;
            if (state_reg == ST_ARMED) begin
              if (trig_hit) begin
                if (post_count == '0) begin
                  state_reg <= ST_DONE;
                end else begin
                  state_reg     <= ST_POST;
                  remaining_reg <= post_count;
                end
              end
            end else begin
              remaining_reg <= remaining_reg - CNT_W'(1);
              if (remaining_reg == CNT_W'(1)) state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (arm) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= '0;
            state_reg  <= ST_ARMED;
          end else if (rd_valid && rd_ready) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg  <= count_reg - CNT_W'(1);
            if (count_reg == CNT_W'(1)) state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rd_valid = (state_reg == ST_DONE) && (count_reg != '0);
  assign rd_data  = rd_valid ? mem_payload[rd_ptr_reg] : '0;
  assign rd_ch    = rd_valid ? mem_ch[rd_ptr_reg]      : '0;
  assign rd_ts    = rd_valid ? mem_ts[rd_ptr_reg]      : '0;
  assign state    = state_reg;
  assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_sifive_scope_tl_trace_capture.sv
// Self-checking bench for sifive_scope_tl_trace_capture: directed scenarios plus a
// randomized phase, all compared every cycle against a queue-based trace model.
module tb_sifive_scope_tl_trace_capture;

  localparam int NUM_CH    = 5;
  localparam int PAYLOAD_W = 64;
  localparam int DEPTH     = 16;
  localparam int TS_W      = 4;
  localparam int CNT_W     = 5;
  localparam int CH_W      = 3;

  logic                        clock = 1'b0;
  logic                        reset;
  logic [NUM_CH-1:0]           ch_valid, ch_ready, ch_enable, trig_mask;
  logic [NUM_CH*PAYLOAD_W-1:0] ch_payload;
  logic [CNT_W-1:0]            post_count;
  logic                        arm, rd_ready;
  logic                        rd_valid;
  logic [PAYLOAD_W-1:0]        rd_data;
  logic [CH_W-1:0]             rd_ch;
  logic [TS_W-1:0]             rd_ts;
  logic [1:0]                  state;
  logic [7:0]                  drop_cnt;

  sifive_scope_tl_trace_capture #(
    .NUM_CH(NUM_CH), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clock(clock), .reset(reset), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_payload(ch_payload), .ch_enable(ch_enable), .trig_mask(trig_mask),
    .post_count(post_count), .arm(arm), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_ch(rd_ch), .rd_ts(rd_ts), .state(state), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [63:0] p;
    int          ch;
    int          ts;
  } ent_t;

  ent_t m_q[$];
  int   m_state = 0;
  int   m_rem   = 0;
  int   m_drop  = 0;
  int   m_ts    = 0;
  bit   started = 0;

  always @(posedge clock) begin : model
    logic [NUM_CH-1:0] f;
    int lo;
    ent_t e;
    f = ch_valid & ch_ready & ch_enable;
    if (reset) begin
      m_q.delete();
      m_state = 0; m_rem = 0; m_drop = 0; m_ts = 0;
    end else begin
      case (m_state)
        0: if (arm) begin m_q.delete(); m_drop = 0; m_state = 1; end
        1, 2: if (f != 0) begin
          lo = 0;
          for (int i = NUM_CH - 1; i >= 0; i--) if (f[i]) lo = i;
          e.p = ch_payload[lo*PAYLOAD_W +: PAYLOAD_W];
          e.ch = lo;
          e.ts = m_ts;
          if (m_q.size() == DEPTH) void'(m_q.pop_front());
          m_q.push_back(e);
          m_drop = m_drop + $countones(f) - 1;
          if (m_drop > 255) m_drop = 255;
          if (m_state == 1) begin
            if (trig_mask[lo]) begin
              if (post_count == 0) m_state = 3;
              else begin m_state = 2; m_rem = int'(post_count); end
            end
          end else begin
            m_rem--;
            if (m_rem == 0) m_state = 3;
          end
        end
        3: begin
          if (arm) begin m_q.delete(); m_drop = 0; m_state = 1; end
          else if (rd_ready && m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_state = 0;
          end
        end
        default: m_state = 0;
      endcase
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    started = 1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    bit ev;
    if (started) begin
      ev = (m_state == 3) && (m_q.size() > 0);
      check("state",    64'(state),    64'(m_state));
      check("rd_valid", 64'(rd_valid), 64'(ev));
      check("rd_data",  rd_data,       ev ? m_q[0].p : 64'd0);
      check("rd_ch",    64'(rd_ch),    ev ? 64'(m_q[0].ch) : 64'd0);
      check("rd_ts",    64'(rd_ts),    ev ? 64'(m_q[0].ts) : 64'd0);
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input int ch, input logic [63:0] p);
    ch_valid = '0; ch_ready = '0;
    ch_valid[ch] = 1'b1; ch_ready[ch] = 1'b1;
    ch_payload[ch*PAYLOAD_W +: PAYLOAD_W] = p;
    tick();
    ch_valid = '0; ch_ready = '0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wait_ts(input int t);
    for (int k = 0; k < 40; k++) begin
      if (m_ts == t) return;
      tick();
    end
    n_checks++; n_fail++;
    $display("FAIL wait_ts: timestamp %0d not reached, now %0d", t, m_ts);
  endtask

  logic [63:0] got_p[$];
  int          got_ch[$];
  int          got_ts[$];

  task automatic drain();
    got_p.delete(); got_ch.delete(); got_ts.delete();
    for (int k = 0; k < 40 && state == 2'd3; k++) begin
      got_p.push_back(rd_data); got_ch.push_back(int'(rd_ch)); got_ts.push_back(int'(rd_ts));
      $display("pop %0d: data=0x%0h ch=%0d ts=%0d", k, rd_data, rd_ch, rd_ts);
      rd_ready = 1'b1; tick();
    end
    rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ch_valid = '0; ch_ready = '0; ch_enable = '1; trig_mask = '0;
    ch_payload = '0; post_count = '0; arm = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_state", 64'(state), 64'd0);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);

    // 1: single trigger beat, post_count 0
    trig_mask = 5'b00100; post_count = 0;
    pulse_arm();
    wait_ts(10);
    beat(2, 64'hA5);
    check("t1_state_done", 64'(state), 64'd3);
    check("t1_data", rd_data, 64'hA5);
    check("t1_ch", 64'(rd_ch), 64'd2);
    check("t1_ts", 64'(rd_ts), 64'd10);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("t1_idle", 64'(state), 64'd0);

    // 2: overwrite with post-trigger beats
    trig_mask = 5'b00010; post_count = 3;
    pulse_arm();
    for (int n = 0; n < 20; n++) beat(0, 64'(n));
    beat(1, 64'd100);
    check("t2_post", 64'(state), 64'd2);
    for (int n = 20; n < 23; n++) beat(0, 64'(n));
    drain();
    check("t2_count", 64'(got_p.size()), 64'd16);
    check("t2_oldest", got_p[0], 64'd8);
    check("t2_trig_data", got_p[12], 64'd100);
    check("t2_trig_ch", 64'(got_ch[12]), 64'd1);
    check("t2_last", got_p[15], 64'd22);
    check("t2_idle", 64'(state), 64'd0);

    // 3: collisions and saturation
    trig_mask = '0;
    pulse_arm();
    ch_valid = 5'b01011; ch_ready = 5'b01011;
    tick();
    check("t3_drop2", 64'(drop_cnt), 64'd2);
    repeat (199) tick();
    ch_valid = '0; ch_ready = '0;
    check("t3_drop_sat", 64'(drop_cnt), 64'd255);
    check("t3_armed", 64'(state), 64'd1);

    // 4: disabled trigger channel and valid-without-ready
    do_reset();
    trig_mask = 5'b00010; post_count = 0; ch_enable = 5'b11101;
    pulse_arm();
    beat(1, 64'd55);
    check("t4_armed", 64'(state), 64'd1);
    ch_valid = 5'b00001; ch_ready = '0; tick(); ch_valid = '0;
    ch_enable = '1;
    beat(1, 64'd77);
    drain();
    check("t4_entries", 64'(got_p.size()), 64'd1);
    check("t4_data", got_p[0], 64'd77);

    // 5: reset mid-POST and mid-readout, arm ignored in POST
    trig_mask = 5'b00010; post_count = 5;
    pulse_arm();
    beat(1, 64'd1);
    check("t5_post", 64'(state), 64'd2);
    pulse_arm();
    check("t5_arm_ignored", 64'(state), 64'd2);
    beat(0, 64'd2);
    do_reset();
    check("t5_rst_idle", 64'(state), 64'd0);
    check("t5_rst_valid", 64'(rd_valid), 64'd0);
    post_count = 0;
    pulse_arm();
    beat(0, 64'd3);
    beat(1, 64'd4);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("t5_second", rd_data, 64'd4);
    do_reset();
    check("t5_rst2_idle", 64'(state), 64'd0);
    check("t5_rst2_valid", 64'(rd_valid), 64'd0);
    check("t5_rst2_data", rd_data, 64'd0);

    // 6: timestamp wrap
    pulse_arm();
    wait_ts(15);
    beat(0, 64'h15);
    beat(0, 64'h16);
    beat(1, 64'h17);
    drain();
    check("t6_ts_15", 64'(got_ts[0]), 64'd15);
    check("t6_ts_0", 64'(got_ts[1]), 64'd0);
    check("t6_ts_1", 64'(got_ts[2]), 64'd1);

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      ch_valid   = 5'($urandom);
      ch_ready   = 5'($urandom);
      ch_enable  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : '1;
      for (int i = 0; i < NUM_CH; i++)
        ch_payload[i*PAYLOAD_W +: PAYLOAD_W] = {$urandom, $urandom};
      if (c % 37 == 0) trig_mask = ($urandom_range(0, 2) == 0) ? 5'($urandom) : '0;
      post_count = 5'($urandom_range(0, DEPTH));
      arm        = ($urandom_range(0, 15) == 0);
      rd_ready   = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0; arm = 1'b0; rd_ready = 1'b0; ch_valid = '0; ch_ready = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
